// File: rtl/multicycle_sequencer.sv
// Moore control sequencer for a multi-cycle RV32I datapath (fetch/decode/execute/memory/writeback).
// Define SEQ_INSTRET_EN to build the retired-instruction counter; otherwise instret_o is tied to 0.
module multicycle_sequencer #(
  parameter int unsigned MEM_WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        branch_taken_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        reg_write_o,
  output logic        dmem_wren_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_sel_o,
  output logic [1:0]  writeback_mux_o,
  output logic        pc_src_o,
  output logic        instr_done_o,
  output logic        halted_o,
  output logic [31:0] instret_o
);

  localparam logic [2:0] WaitMax = 3'(MEM_WAIT_CYCLES);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpFence  = 7'b0001111;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecute, StMemory, StWriteback, StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q;

  // Branch condition is resolved externally; funct3 is only exposed for future decoding.
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (cnt_q == WaitMax) state_d = StDecode;
      StDecode: begin
        case (opcode_i)
          OpLui, OpFence:                     state_d = StWriteback;
          OpR, OpI, OpLoad, OpStore, OpJalr,
          OpAuipc, OpJal, OpBranch:           state_d = StExecute;
          default:                            state_d = StHalt;
        endcase
      end
      StExecute: begin
        if (opcode_i == OpLoad || opcode_i == OpStore) state_d = StMemory;
        else                                           state_d = StWriteback;
      end
      StMemory: begin
        if (opcode_i == OpStore || cnt_q == WaitMax) state_d = StWriteback;
      end
      StWriteback: state_d = StFetch;
      StHalt:      state_d = StHalt;
      default:     state_d = StFetch;
    endcase
  end

  // Counter restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFetch;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)  cnt_q <= 3'd0;
      else if (cnt_q < WaitMax) cnt_q <= cnt_q + 3'd1;
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    dmem_wren_o     = 1'b0;
    alu_src_a_o     = 2'b00;
    alu_src_b_o     = 2'b00;
    alu_op_sel_o    = 2'b00;
    writeback_mux_o = 2'b00;
    pc_src_o        = 1'b0;
    instr_done_o    = 1'b0;
    halted_o        = 1'b0;
    case (state_q)
      StFetch: ir_write_o = (cnt_q == WaitMax);
      StExecute: begin
        case (opcode_i)
          OpR: begin
            alu_src_a_o = 2'b01;
          end
          OpI: begin
            alu_src_a_o  = 2'b01;
            alu_src_b_o  = 2'b10;
            alu_op_sel_o = 2'b10;
          end
          OpLoad, OpStore, OpJalr: begin
            alu_src_a_o  = 2'b01;
            alu_src_b_o  = 2'b10;
            alu_op_sel_o = 2'b01;
          end
          OpAuipc, OpJal, OpBranch: begin
            alu_src_b_o  = 2'b10;
            alu_op_sel_o = 2'b01;
          end
          default: ;
        endcase
      end
      StMemory: dmem_wren_o = (opcode_i == OpStore);
      StWriteback: begin
        // ALU computes pc+4 for the sequential next-PC / link value.
        alu_src_b_o  = 2'b01;
        alu_op_sel_o = 2'b01;
        pc_write_o   = 1'b1;
        instr_done_o = 1'b1;
        pc_src_o     = (opcode_i == OpJal) || (opcode_i == OpJalr) ||
                       ((opcode_i == OpBranch) && branch_taken_i);
        case (opcode_i)
          OpR, OpI, OpAuipc: reg_write_o = 1'b1;
          OpLoad: begin
            reg_write_o     = 1'b1;
            writeback_mux_o = 2'b01;
          end
          OpLui: begin
            reg_write_o     = 1'b1;
            writeback_mux_o = 2'b10;
          end
          OpJal, OpJalr: begin
            reg_write_o     = 1'b1;
            writeback_mux_o = 2'b11;
          end
          default: ;
        endcase
      end
      StHalt:  halted_o = 1'b1;
      default: ;
    endcase
  end

`ifdef SEQ_INSTRET_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)           instret_q <= 32'd0;
    else if (instr_done_o) instret_q <= instret_q + 32'd1;
  end

  assign instret_o = instret_q;
`else
  assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a driver queues expected per-instruction behaviour,
// a negedge monitor records the strobe trace and compares it when WRITEBACK or HALT appears.
module tb_multicycle_sequencer;

  localparam int MW = 1;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [6:0]  opcode_i = 7'h00;
  logic [2:0]  funct3_i = 3'd0;
  logic        branch_taken_i = 1'b0;
  logic        pc_write_o, ir_write_o, reg_write_o, dmem_wren_o;
  logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_sel_o, writeback_mux_o;
  logic        pc_src_o, instr_done_o, halted_o;
  logic [31:0] instret_o;

  multicycle_sequencer #(.MEM_WAIT_CYCLES(MW)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .opcode_i       (opcode_i),
    .funct3_i       (funct3_i),
    .branch_taken_i (branch_taken_i),
    .pc_write_o     (pc_write_o),
    .ir_write_o     (ir_write_o),
    .reg_write_o    (reg_write_o),
    .dmem_wren_o    (dmem_wren_o),
    .alu_src_a_o    (alu_src_a_o),
    .alu_src_b_o    (alu_src_b_o),
    .alu_op_sel_o   (alu_op_sel_o),
    .writeback_mux_o(writeback_mux_o),
    .pc_src_o       (pc_src_o),
    .instr_done_o   (instr_done_o),
    .halted_o       (halted_o),
    .instret_o      (instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         halt;
    int         lat;      // cycle index of WRITEBACK (or first HALT cycle)
    int         exe_at;   // cycle index of EXECUTE, -1 if skipped
    logic [5:0] exe_sel;  // {alu_src_a, alu_src_b, alu_op_sel} in EXECUTE
    bit         rw;
    logic [1:0] wb;
    bit         ps;
    int         wren_at;  // cycle index of the store strobe, -1 if none
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour from the instruction-class rules, with cycle 0 = first FETCH cycle.
  function automatic exp_t model(input logic [6:0] op, input logic bt);
    exp_t e;
    int   ex;
    ex = MW + 2;
    e = '{halt: 1'b0, lat: MW + 3, exe_at: ex, exe_sel: 6'b0, rw: 1'b0, wb: 2'b00, ps: 1'b0,
          wren_at: -1};
    case (op)
      7'h33: begin e.exe_sel = 6'b01_00_00; e.rw = 1; end
      7'h13: begin e.exe_sel = 6'b01_10_10; e.rw = 1; end
      7'h03: begin e.exe_sel = 6'b01_10_01; e.rw = 1; e.wb = 2'b01; e.lat = ex + 1 + MW + 1; end
      7'h23: begin e.exe_sel = 6'b01_10_01; e.wren_at = ex + 1; e.lat = ex + 2; end
      7'h67: begin e.exe_sel = 6'b01_10_01; e.rw = 1; e.wb = 2'b11; e.ps = 1; end
      7'h17: begin e.exe_sel = 6'b00_10_01; e.rw = 1; end
      7'h6F: begin e.exe_sel = 6'b00_10_01; e.rw = 1; e.wb = 2'b11; e.ps = 1; end
      7'h63: begin e.exe_sel = 6'b00_10_01; e.ps = bt; end
      7'h37: begin e.exe_at = -1; e.lat = MW + 2; e.rw = 1; e.wb = 2'b10; end
      7'h0F: begin e.exe_at = -1; e.lat = MW + 2; end
      default: begin e.halt = 1; e.exe_at = -1; e.lat = MW + 2; end
    endcase
    return e;
  endfunction

  // Monitor state
  int         cyc = 0;
  int         n_ir = 0, ir_at = -1, n_wr = 0, wr_at = -1;
  logic [4:0] early = '0;
  bit         in_halt = 0;
  int         ret_cnt = 0;
  logic [5:0] sel_hist [64];
  logic [14:0] outv;
  logic [5:0]  sel;

  assign outv = {pc_write_o, ir_write_o, reg_write_o, dmem_wren_o, alu_src_a_o, alu_src_b_o,
                 alu_op_sel_o, writeback_mux_o, pc_src_o, instr_done_o, halted_o};
  assign sel  = {alu_src_a_o, alu_src_b_o, alu_op_sel_o};

  function automatic int hist_bad(input int upto, input int exe_at, input logic [5:0] exe_sel);
    int bad = 0;
    for (int k = 0; k < upto && k < 64; k++) begin
      if (sel_hist[k] !== ((k == exe_at) ? exe_sel : 6'b0)) bad++;
    end
    return bad;
  endfunction

  task automatic clear_trace();
    cyc = 0; n_ir = 0; ir_at = -1; n_wr = 0; wr_at = -1; early = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      chk("reset_outputs", 32'(outv), 32'd0);
      chk("reset_instret", instret_o, 32'd0);
      clear_trace();
      in_halt = 0;
      ret_cnt = 0;
    end else begin
`ifdef SEQ_INSTRET_EN
      chk("instret", instret_o, 32'(ret_cnt));
`else
      chk("instret_tied", instret_o, 32'd0);
`endif
      if (in_halt) begin
        chk("halt_hold", 32'(outv), 32'd1);
      end else begin
        if (cyc < 64) sel_hist[cyc] = sel;
        if (ir_write_o) begin n_ir++; ir_at = cyc; end
        if (dmem_wren_o) begin n_wr++; wr_at = cyc; end
        if (instr_done_o || halted_o) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_end actual=outputs 0x%0h expected=no completion", outv);
          end else begin
            e = q.pop_front();
            chk("kind_halt", 32'(halted_o), 32'(e.halt));
            chk("latency", 32'(cyc), 32'(e.lat));
            chk("ir_write_count", 32'(n_ir), 32'd1);
            chk("ir_write_cycle", 32'(ir_at), 32'(MW));
            chk("early_strobes", 32'(early), 32'd0);
            chk("sel_trace", 32'(hist_bad(cyc, e.exe_at, e.exe_sel)), 32'd0);
            chk("wren_count", 32'(n_wr), (e.wren_at >= 0) ? 32'd1 : 32'd0);
            if (e.wren_at >= 0) chk("wren_cycle", 32'(wr_at), 32'(e.wren_at));
            if (e.halt) begin
              chk("halt_outputs", 32'(outv), 32'd1);
              in_halt = 1;
            end else begin
              chk("wb_sel", 32'(sel), 32'b00_01_01);
              chk("pc_write", 32'(pc_write_o), 32'd1);
              chk("reg_write", 32'(reg_write_o), 32'(e.rw));
              chk("wb_mux", 32'(writeback_mux_o), 32'(e.wb));
              chk("pc_src", 32'(pc_src_o), 32'(e.ps));
              chk("wb_no_wren", 32'(dmem_wren_o), 32'd0);
              ret_cnt++;
            end
          end
          clear_trace();
        end else begin
          early = early | {reg_write_o, pc_write_o, pc_src_o, writeback_mux_o};
          cyc++;
        end
      end
    end
  end

  // Called just after a rising edge; checks the asynchronous clear before the next edge.
  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(outv), 32'd0);
    chk("async_reset_instret", instret_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic bt);
    exp_t e;
    int   t;
    e = model(op, bt);
    q.push_back(e);
    opcode_i = op;
    branch_taken_i = bt;
    funct3_i = 3'($urandom);
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout op=0x%0h actual=no completion expected=done within 100 cycles", op);
      q.delete();
      do_reset();
    end else if (e.halt) begin
      repeat (3) @(posedge clk);
      #1;
      do_reset();
    end
  endtask

  // Start an instruction and reset it asynchronously at cycle index k.
  task automatic abort_at(input logic [6:0] op, input int k);
    opcode_i = op;
    repeat (k) @(posedge clk);
    #1;
    do_reset();
  endtask

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h17, 7'h6F, 7'h63, 7'h37,
                           7'h0F, 7'h73};

  initial begin
    logic [6:0] op;
    int         idx;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    run_instr(7'h33, 1'b0);   // ADD
    run_instr(7'h03, 1'b0);   // LW
    run_instr(7'h23, 1'b0);   // SW
    run_instr(7'h63, 1'b1);   // BEQ taken
    run_instr(7'h63, 1'b0);   // BEQ not taken
    run_instr(7'h6F, 1'b0);   // JAL
    run_instr(7'h37, 1'b0);   // LUI
    run_instr(7'h0F, 1'b1);   // FENCE
    run_instr(7'h7F, 1'b0);   // illegal -> HALT, then reset
    run_instr(7'h33, 1'b0);
    abort_at(7'h03, MW + 4);  // second MEMORY cycle of a load
    run_instr(7'h33, 1'b0);
    abort_at(7'h13, MW + 2);  // EXECUTE of an I-ALU op, selects are live
    run_instr(7'h13, 1'b0);
    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(0, 12);
      if (idx >= 11) op = 7'($urandom);
      else begin
        op = ops[idx];
      end
      run_instr(op, 1'($urandom));
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
